// File: rtl/led_pkg.sv
// ============================================================================
// Module  : led_pkg
// Brief   : Shared mode codes, FSM encoding and sizing helper for led_sched.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package led_pkg;

    localparam logic [1:0] LED_OFF  = 2'b00;
    localparam logic [1:0] LED_SLOW = 2'b01;
    localparam logic [1:0] LED_FAST = 2'b10;
    localparam logic [1:0] LED_ON   = 2'b11;

    localparam logic [0:0] ST_LAMP  = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    localparam int         NUM_LEDS     = 16;
    localparam logic [4:0] LAMP_ALL_IDX = 5'd16;
    localparam logic [1:0] STRETCH_LOAD = 2'd3;

    // Bits needed to hold 0..value-1; never less than one bit.
    function automatic int clogb2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/led_act_stretch.sv
// ============================================================================
// Module  : led_act_stretch
// Brief   : 2-bit loadable down-counter stretching one LED's activity pulse.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module led_act_stretch
    import led_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic act,
    input  logic tick,
    input  logic en,
    output logic active
);

    logic [1:0] r_cnt;

    // A fresh pulse always reloads, even on a tick cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= 2'd0;
        end else if (en) begin
            if (act) begin
                r_cnt <= STRETCH_LOAD;
            end else if (tick && (r_cnt != 2'd0)) begin
                r_cnt <= r_cnt - 2'd1;
            end
        end
    end

    assign active = (r_cnt != 2'd0);

endmodule

`default_nettype wire

// File: rtl/led_sched.sv
// ============================================================================
// Module  : led_sched
// Brief   : Merges base modes, error overrides and stretched activity into
//           16 registered LED mode codes; runs a lamp-test sweep.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module led_sched
    import led_pkg::*;
#(
    parameter int LAMP_STEP_CYC = 10000000,
    parameter int TICK_CYC      = 2000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_wr,
    input  logic [3:0]  cfg_addr,
    input  logic [1:0]  cfg_wdata,
    output logic [1:0]  cfg_rdata,
    input  logic [15:0] act,
    input  logic [15:0] err,
    input  logic        lamp_test_req,
    output logic [31:0] led_mode,
    output logic        busy
);

    localparam int STEP_W = clogb2(LAMP_STEP_CYC);
    localparam int TICK_W = clogb2(TICK_CYC);
    localparam logic [STEP_W-1:0] c_STEP_LAST = STEP_W'(LAMP_STEP_CYC - 1);
    localparam logic [TICK_W-1:0] c_TICK_LAST = TICK_W'(TICK_CYC - 1);

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [4:0]        r_step;
    logic [4:0]        w_step_nxt;
    logic [STEP_W-1:0] r_step_cnt;
    logic [STEP_W-1:0] w_step_cnt_nxt;
    logic [TICK_W-1:0] r_tick_cnt;
    logic              w_tick;
    logic              w_run_en;
    logic [1:0]        r_base [NUM_LEDS];
    logic [1:0]        r_rdata;
    logic [15:0]       w_active;
    logic [31:0]       w_lamp_mode;
    logic [31:0]       w_run_mode;
    logic [31:0]       w_led_nxt;
    logic              w_busy_nxt;
    logic [31:0]       r_led_mode;
    logic              r_busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_LAMP;
            r_step     <= 5'd0;
            r_step_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_step     <= w_step_nxt;
            r_step_cnt <= w_step_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_step_nxt     = r_step;
        w_step_cnt_nxt = r_step_cnt;
        case (r_state)
            ST_LAMP: begin
                if (r_step_cnt == c_STEP_LAST) begin
                    w_step_cnt_nxt = '0;
                    if (r_step == LAMP_ALL_IDX) begin
                        w_state_nxt = ST_RUN;
                        w_step_nxt  = 5'd0;
                    end else begin
                        w_step_nxt = r_step + 5'd1;
                    end
                end else begin
                    w_step_cnt_nxt = r_step_cnt + STEP_W'(1);
                end
            end
            ST_RUN: begin
                if (lamp_test_req) begin
                    w_state_nxt    = ST_LAMP;
                    w_step_nxt     = 5'd0;
                    w_step_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt    = ST_LAMP;
                w_step_nxt     = 5'd0;
                w_step_cnt_nxt = '0;
            end
        endcase
    end

    // The output register is loaded from the next-state view so that a
    // step change or the LAMP->RUN handover shows on the same edge.
    always_comb begin
        w_lamp_mode = '0;
        if (w_step_nxt == LAMP_ALL_IDX) begin
            w_lamp_mode = '1;
        end else begin
            w_lamp_mode[{w_step_nxt[3:0], 1'b0} +: 2] = LED_ON;
        end

        w_run_mode = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (err[i]) begin
                w_run_mode[2*i +: 2] = LED_FAST;
            end else if (w_active[i]) begin
                w_run_mode[2*i +: 2] = LED_ON;
            end else begin
                w_run_mode[2*i +: 2] = r_base[i];
            end
        end

        if (w_state_nxt == ST_LAMP) begin
            w_led_nxt  = w_lamp_mode;
            w_busy_nxt = 1'b1;
        end else begin
            w_led_nxt  = w_run_mode;
            w_busy_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_led_mode <= 32'h0000_0003;
            r_busy     <= 1'b1;
        end else begin
            r_led_mode <= w_led_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
        end
    end

    assign w_tick = (r_tick_cnt == c_TICK_LAST);

    // Readback samples the pre-write value; a same-cycle write shows next read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                r_base[i] <= LED_OFF;
            end
            r_rdata <= LED_OFF;
        end else begin
            if (cfg_wr) begin
                r_base[cfg_addr] <= cfg_wdata;
            end
            r_rdata <= r_base[cfg_addr];
        end
    end

    assign w_run_en = (r_state == ST_RUN);

    generate
        for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_stretch
            led_act_stretch u_stretch (
                .clk    (clk),
                .rst    (rst),
                .act    (act[gi]),
                .tick   (w_tick),
                .en     (w_run_en),
                .active (w_active[gi])
            );
        end
    endgenerate

    assign led_mode  = r_led_mode;
    assign busy      = r_busy;
    assign cfg_rdata = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_led_sched.sv
// ============================================================================
// Module  : tb_led_sched
// Brief   : Scoreboard bench for led_sched with short lamp and tick periods.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_sched;

    localparam int c_K_LED   = 0;
    localparam int c_K_BUSY  = 1;
    localparam int c_K_RDATA = 2;

    logic        clk;
    logic        rst;
    logic        cfg_wr;
    logic [3:0]  cfg_addr;
    logic [1:0]  cfg_wdata;
    logic [1:0]  cfg_rdata;
    logic [15:0] act;
    logic [15:0] err;
    logic        lamp_test_req;
    logic [31:0] led_mode;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc;
    int hi;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
        string       tag;
    } sb_t;

    sb_t sb[$];

    led_sched #(
        .LAMP_STEP_CYC (4),
        .TICK_CYC      (8)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_wr        (cfg_wr),
        .cfg_addr      (cfg_addr),
        .cfg_wdata     (cfg_wdata),
        .cfg_rdata     (cfg_rdata),
        .act           (act),
        .err           (err),
        .lamp_test_req (lamp_test_req),
        .led_mode      (led_mode),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since the last reset release.
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic void push(input int c, input int k, input logic [31:0] v, input string t);
        sb_t e;
        e.cyc  = c;
        e.kind = k;
        e.val  = v;
        e.tag  = t;
        sb.push_back(e);
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            sb_t e;
            e = sb.pop_front();
            if (e.cyc != cyc) begin
                check({e.tag, "_missed"}, cyc, e.cyc);
            end else begin
                case (e.kind)
                    c_K_LED:  check(e.tag, led_mode, e.val);
                    c_K_BUSY: check(e.tag, {31'b0, busy}, e.val);
                    default:  check(e.tag, {30'b0, cfg_rdata}, e.val);
                endcase
            end
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got cycle %0d required end", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; cfg_wr = 1'b0; cfg_addr = 4'd0; cfg_wdata = 2'd0;
        act = '0; err = '0; lamp_test_req = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_led", led_mode, 32'h0000_0003);
        check("rst_busy", {31'b0, busy}, 32'd1);
        check("rst_rdata", {30'b0, cfg_rdata}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Power-up sweep; err/act/request applied mid-sweep must be ignored.
        push(1,  c_K_LED,  32'h0000_0003, "sweep_s0");
        push(1,  c_K_BUSY, 32'd1,         "sweep_busy0");
        push(3,  c_K_LED,  32'h0000_0003, "sweep_s0_end");
        push(4,  c_K_LED,  32'h0000_000C, "sweep_s1");
        push(8,  c_K_LED,  32'h0000_0030, "sweep_s2");
        push(22, c_K_LED,  32'h0000_0C00, "sweep_s5_err");
        push(63, c_K_LED,  32'hC000_0000, "sweep_s15");
        push(64, c_K_LED,  32'hFFFF_FFFF, "sweep_all");
        push(67, c_K_BUSY, 32'd1,         "sweep_busy_end");
        push(68, c_K_LED,  32'h0000_0000, "run_entry_led");
        push(68, c_K_BUSY, 32'd0,         "run_entry_busy");
        wait_cyc(10); err = '1; act = '1;
        wait_cyc(20); lamp_test_req = 1'b1;
        wait_cyc(21); lamp_test_req = 1'b0;
        wait_cyc(60); err = '0; act = '0;

        wait_cyc(70);
        cfg_wr = 1'b1; cfg_addr = 4'd5; cfg_wdata = 2'b01;
        push(71, c_K_RDATA, 32'd0,         "cfg_rd_old");
        push(71, c_K_LED,   32'h0000_0000, "cfg_led_pre");
        push(72, c_K_RDATA, 32'd1,         "cfg_rd_new");
        push(72, c_K_LED,   32'h0000_0400, "cfg_led_new");
        wait_cyc(71); cfg_wr = 1'b0;

        wait_cyc(74); err = 16'h0021;
        push(75, c_K_LED, 32'h0000_0802, "err_on");
        wait_cyc(77); err = '0;
        push(78, c_K_LED, 32'h0000_0400, "err_off");

        wait_cyc(80); act = 16'h0080;
        push(82,  c_K_LED, 32'h0000_C400, "act_start");
        push(104, c_K_LED, 32'h0000_C400, "act_last");
        push(105, c_K_LED, 32'h0000_0400, "act_end");
        wait_cyc(81); act = '0;
        wait_cyc(82);
        hi = 0;
        while (led_mode[15:14] == 2'b11 && hi < 40) begin
            hi++;
            @(negedge clk);
        end
        check("act_stretch_len_in_range", {31'b0, (hi >= 17 && hi <= 24)}, 32'd1);

        // Reload landing on a tick edge must win over the decrement.
        wait_cyc(110); act = 16'h0080;
        push(113, c_K_LED, 32'h0000_C400, "reload_pre");
        push(125, c_K_LED, 32'h0000_C400, "reload_low");
        push(129, c_K_LED, 32'h0000_C400, "reload_tick");
        push(152, c_K_LED, 32'h0000_C400, "reload_last");
        push(153, c_K_LED, 32'h0000_0400, "reload_end");
        wait_cyc(111); act = '0;
        wait_cyc(127); act = 16'h0080;
        wait_cyc(128); act = '0;

        // Request together with a write; second request mid-sweep ignored.
        wait_cyc(160);
        lamp_test_req = 1'b1; cfg_wr = 1'b1; cfg_addr = 4'd9; cfg_wdata = 2'b10;
        push(161, c_K_LED,   32'h0000_0003, "req_led");
        push(161, c_K_BUSY,  32'd1,         "req_busy");
        push(162, c_K_RDATA, 32'd2,         "req_wr_rd");
        push(189, c_K_LED,   32'h0000_C000, "req_norestart");
        push(189, c_K_BUSY,  32'd1,         "req_busy_mid");
        push(202, c_K_RDATA, 32'd3,         "lamp_wr_rd");
        push(225, c_K_LED,   32'hFFFF_FFFF, "req_all");
        push(228, c_K_BUSY,  32'd1,         "req_busy_end");
        push(229, c_K_LED,   32'h0008_04C0, "req_base_kept");
        push(229, c_K_BUSY,  32'd0,         "req_run_busy");
        wait_cyc(161); lamp_test_req = 1'b0; cfg_wr = 1'b0;
        wait_cyc(186); lamp_test_req = 1'b1;
        wait_cyc(187); lamp_test_req = 1'b0;
        wait_cyc(200); cfg_wr = 1'b1; cfg_addr = 4'd3; cfg_wdata = 2'b11;
        wait_cyc(201); cfg_wr = 1'b0;

        // Asynchronous reset in the middle of a sweep.
        wait_cyc(232); lamp_test_req = 1'b1;
        push(233, c_K_LED,  32'h0000_0003, "req2_led");
        push(233, c_K_BUSY, 32'd1,         "req2_busy");
        wait_cyc(233); lamp_test_req = 1'b0;
        wait_cyc(270);
        #2 rst = 1'b0;
        #1;
        check("async_rst_led", led_mode, 32'h0000_0003);
        check("async_rst_busy", {31'b0, busy}, 32'd1);
        check("async_rst_rdata", {30'b0, cfg_rdata}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        push(2,  c_K_RDATA, 32'd0,         "rst2_rd_lost");
        push(4,  c_K_LED,   32'h0000_000C, "rst2_s1");
        push(68, c_K_LED,   32'h0000_0000, "rst2_base_lost");
        push(68, c_K_BUSY,  32'd0,         "rst2_busy");
        wait_cyc(70);

        check("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/led_sched.md
Name: led_sched

Overview:
Scheduler that produces the 16 two-bit LED mode codes consumed by the LED scan/blink controller. Merges host-configured base modes, per-LED error overrides and stretched activity pulses. Runs a lamp-test sweep after reset and on request. Outputs are registered and drive the controller's led0..led15 inputs directly.

Parameters:
LAMP_STEP_CYC, 10000000, clock cycles per lamp-test step (100 ms at 100 MHz)
TICK_CYC, 2000000, clock cycles per activity-stretch tick (20 ms at 100 MHz)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
cfg_wr  in  1  single-cycle write strobe for base mode
cfg_addr  in  4  LED index for write and readback
cfg_wdata  in  2  base mode to write
cfg_rdata  out  2  registered base mode of LED cfg_addr
act  in  16  per-LED activity pulses, any width
err  in  16  per-LED error level
lamp_test_req  in  1  single-cycle lamp-test request
led_mode  out  32  packed modes; bits [2i+1:2i] feed LED i
busy  out  1  high while lamp test runs

Behaviour:
- Mode codes: 00 off, 01 slow blink, 10 fast blink, 11 on.
- Reset (rst low, async): state LAMP, step index 0, step counter 0, all base modes 00, all stretch counters 0, tick prescaler 0.
- Reset output values: led_mode=32'h0000_0003, busy=1, cfg_rdata=00.
- FSM LAMP:
  - step index 0..15 shows LED index=11 and all other LEDs 00.
  - step 16 shows all LEDs 11.
  - Each step lasts LAMP_STEP_CYC cycles.
  - After step 16 completes, go to RUN. busy falls and led_mode takes the RUN value on the same edge.
  - err, act and lamp_test_req are ignored. act pulses are not stretched.
- FSM RUN, per LED i, registered one cycle after the inputs:
  - err[i]=1 gives 10.
  - else stretch counter i nonzero gives 11.
  - else base mode i.
  - busy=0.
- lamp_test_req in RUN: next edge goes to LAMP, step 0, counter 0, busy=1. A request in LAMP is ignored (no restart).
- Config interface:
  - cfg_wr writes cfg_wdata to base mode cfg_addr in any state.
  - The new value reaches led_mode one cycle later in RUN.
  - cfg_rdata = base[cfg_addr] registered, one-cycle latency. A same-cycle write is visible at the next read.
  - cfg_wr and lamp_test_req in the same cycle are both honoured.
- Activity stretch (RUN only):
  - Free-running prescaler pulses tick every TICK_CYC cycles.
  - act[i]=1 loads stretch counter i with 3.
  - Otherwise tick decrements a nonzero counter.
  - act and tick in the same cycle: load wins.
  - Visible stretch is between 2*TICK_CYC and 3*TICK_CYC cycles after act falls.
- Widths: counters sized by clogb2 of the parameter. Counters compare to parameter-1 and wrap to 0, with no overflow state.
- Reset mid-operation: immediate return to reset values. Base modes are lost.

Decomposition:
- Package led_pkg holds:
  - mode code constants LED_OFF, LED_SLOW, LED_FAST, LED_ON
  - FSM state encoding ST_LAMP, ST_RUN
  - clogb2 function
- One sub-module, led_act_stretch: 2-bit loadable down-counter with inputs clk, rst, act, tick, en and output active. Instantiated 16 times.
- Lamp FSM, prescalers, base-mode register file and output mux stay in led_sched.

Test Plan:
(All tests use LAMP_STEP_CYC=4, TICK_CYC=8.)
- Reset release -> led_mode=32'h0000_0003, busy=1; after 4 cycles 32'h0000_000C; at cycle 64 32'hFFFF_FFFF; at cycle 68 busy=0 and led_mode=32'h0.
- RUN, cfg_wr addr 5 data 01 -> cfg_rdata=01 one cycle after the write is readable; led_mode[11:10]=01, all other bits 0.
- err[5]=1 with base 01 -> led_mode[11:10]=10 next cycle; err[5]=0 -> back to 01 next cycle; err during lamp sweep has no effect.
- act[7] one-cycle pulse in RUN -> led_mode[15:14]=11 for 17..24 cycles, then 00; act on a tick cycle reloads to 3.
- lamp_test_req in RUN -> busy=1 and led_mode=32'h3 next cycle; a second request at step 6 does not restart; base modes intact after return to RUN.
- rst low at step 9 with base[5]=01 -> led_mode=32'h3 immediately, no clock needed; after the sweep, led_mode[11:10]=00.
